// File: rtl/sqrt_pkg.sv
// Shared definitions for the iterative square-root engine: default width,
// FSM state encoding and the partial-remainder width derivation.
package sqrt_pkg;

  localparam int SQRT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } sqrt_state_e;

  // Signed partial remainder needs two bits of headroom above the trial term plus sign
  function automatic int sqrt_aw(input int w);
    return (w / 2) + 3;
  endfunction

endpackage

// File: rtl/addsub_cla.sv
// N-bit combinational adder/subtractor built from 4-bit generate/propagate
// groups with a group-level carry lookahead; subtract inverts b and sets cin.
module addsub_cla #(
  parameter int N = 19
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum
);

  localparam int NG = (N + 3) / 4;

  logic [N-1:0] b_s;
  logic [N-1:0] p_s;
  logic [N-2:0] g_s;
  logic [N-1:0] c_s;
  logic [NG-2:0] gg_s;
  logic [NG-2:0] gp_s;
  logic [NG-1:0] gc_s;

  // Per-bit generate/propagate; the top bit never produces a used carry
  always_comb begin
    b_s = sub ? ~b : b;
    p_s = a ^ b_s;
    g_s = a[N-2:0] & b_s[N-2:0];
  end

  // Group generate/propagate for every group that feeds a higher group
  always_comb begin
    logic gacc;
    logic pacc;
    gg_s = '0;
    gp_s = '0;
    gacc = 1'b0;
    pacc = 1'b1;
    for (int k = 0; k < NG - 1; k++) begin
      gacc = 1'b0;
      pacc = 1'b1;
      for (int j = 3; j >= 0; j--) begin
        gacc = gacc | (pacc & g_s[4*k+j]);
        pacc = pacc & p_s[4*k+j];
      end
      gg_s[k] = gacc;
      gp_s[k] = pacc;
    end
  end

  // Group carry-ins as flat sum-of-products over lower groups and cin
  always_comb begin
    logic cacc;
    logic pacc;
    gc_s = '0;
    cacc = 1'b0;
    pacc = 1'b1;
    for (int k = 0; k < NG; k++) begin
      cacc = 1'b0;
      pacc = 1'b1;
      for (int j = k - 1; j >= 0; j--) begin
        cacc = cacc | (pacc & gg_s[j]);
        pacc = pacc & gp_s[j];
      end
      gc_s[k] = cacc | (pacc & sub);
    end
  end

  // Bit carries inside each group from that group's carry-in
  always_comb begin
    logic cacc;
    logic pacc;
    c_s  = '0;
    cacc = 1'b0;
    pacc = 1'b1;
    for (int n = 0; n < N; n++) begin
      cacc = 1'b0;
      pacc = 1'b1;
      for (int j = (n % 4) - 1; j >= 0; j--) begin
        cacc = cacc | (pacc & g_s[n-(n%4)+j]);
        pacc = pacc & p_s[n-(n%4)+j];
      end
      c_s[n] = cacc | (pacc & gc_s[n/4]);
    end
    sum = p_s ^ c_s;
  end

endmodule

// File: rtl/sqrt_nr_iter.sv
// Non-restoring integer square root: one root bit per clock, then a single
// correction cycle that makes the remainder non-negative.
module sqrt_nr_iter
  import sqrt_pkg::*;
#(
  parameter int W = SQRT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   radicand,
  output logic           ready,
  output logic           valid,
  output logic [W/2-1:0] root,
  output logic [W/2:0]   rem
);

  localparam int H  = W / 2;
  localparam int AW = sqrt_aw(W);
  localparam int CW = $clog2(H);
  localparam logic [CW-1:0] CNT_LOAD = CW'(H - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  sqrt_state_e   state_r;
  sqrt_state_e   state_nx_s;
  logic [W-1:0]  rad_r;
  logic [AW-1:0] r_r;
  logic [H-1:0]  q_r;
  logic [CW-1:0] cnt_r;
  logic [AW-1:0] op_a_s;
  logic [AW-1:0] op_b_s;
  logic [AW-1:0] sum_s;
  logic          sub_s;
  logic          accept_s;

  assign accept_s = start & ready;

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nx_s = CALC;
        else          state_nx_s = IDLE;
      end
      CALC: begin
        if (cnt_r == '0) state_nx_s = FIX;
        else             state_nx_s = CALC;
      end
      FIX:     state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Operand mux for the shared adder: trial step in CALC, correction in FIX
  always_comb begin
    op_a_s = r_r;
    op_b_s = '0;
    sub_s  = 1'b0;
    case (state_r)
      CALC: begin
        op_a_s = {r_r[AW-3:0], rad_r[W-1 -: 2]};
        sub_s  = ~r_r[AW-1];
        if (r_r[AW-1]) op_b_s = {1'b0, q_r, 2'b11};
        else           op_b_s = {1'b0, q_r, 2'b01};
      end
      FIX: begin
        op_a_s = r_r;
        op_b_s = {2'b00, q_r, 1'b1};
        sub_s  = 1'b0;
      end
      default: begin
        op_a_s = r_r;
        op_b_s = '0;
        sub_s  = 1'b0;
      end
    endcase
  end

  addsub_cla #(.N(AW)) u_addsub (
    .a   (op_a_s),
    .b   (op_b_s),
    .sub (sub_s),
    .sum (sum_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nx_s;
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rad_r <= '0;
      r_r   <= '0;
      q_r   <= '0;
      cnt_r <= '0;
      ready <= 1'b1;
      valid <= 1'b0;
      root  <= '0;
      rem   <= '0;
    end else begin
      ready <= (state_nx_s == IDLE);
      valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            rad_r <= radicand;
            r_r   <= '0;
            q_r   <= '0;
            cnt_r <= CNT_LOAD;
          end
        end
        CALC: begin
          r_r   <= sum_s;
          q_r   <= {q_r[H-2:0], ~sum_s[AW-1]};
          rad_r <= {rad_r[W-3:0], 2'b00};
          cnt_r <= cnt_r - CNT_ONE;
        end
        FIX: begin
          if (r_r[AW-1]) r_r <= sum_s;
          else           r_r <= r_r;
          root  <= q_r;
          rem   <= r_r[AW-1] ? sum_s[H:0] : r_r[H:0];
          valid <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_nr_iter.sv
// Scoreboard bench for sqrt_nr_iter: expected root/rem queued at issue time,
// popped and compared on each valid pulse.
module tb_sqrt_nr_iter;

  typedef struct packed {
    logic [15:0] root;
    logic [16:0] rem;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] radicand;
  logic        ready;
  logic        valid;
  logic [15:0] root;
  logic [16:0] rem;

  int   checks;
  int   errors;
  exp_t sb_q[$];
  exp_t mon_e;

  sqrt_nr_iter #(.W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .radicand (radicand),
    .ready    (ready),
    .valid    (valid),
    .root     (root),
    .rem      (rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] r, input logic [16:0] m);
    exp_t e;
    e.root = r;
    e.rem  = m;
    return e;
  endfunction

  // Reference: greedy bit-by-bit floor sqrt in 64-bit arithmetic
  function automatic exp_t ref_sqrt(input logic [31:0] x);
    logic [63:0] r;
    logic [63:0] c;
    logic [63:0] d;
    r = 64'd0;
    for (int b = 15; b >= 0; b--) begin
      c = r | (64'd1 << b);
      if (c * c <= {32'd0, x}) r = c;
    end
    d = {32'd0, x} - r * r;
    return mk(r[15:0], d[16:0]);
  endfunction

  task automatic issue(input logic [31:0] x, input exp_t e, input bit push);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_value("ready_wait", 64'(ready), 64'd1);
    if (ready === 1'b1) begin
      radicand = x;
      start    = 1'b1;
      if (push) sb_q.push_back(e);
      @(negedge clk);
      start    = 1'b0;
      radicand = $urandom;
    end
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (valid !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      check_value("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check_value("root", 64'(root), 64'(mon_e.root));
        check_value("rem", 64'(rem), 64'(mon_e.rem));
        check_value("rem_bound", 64'({1'b0, rem} <= {root, 1'b0}), 64'd1);
      end
    end
  end

  initial begin
    int k;
    int vc;
    int n;
    int sq[10];
    logic [31:0] x;
    logic [63:0] s64;

    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    radicand = 32'd0;
    repeat (3) @(negedge clk);
    check_value("rst_ready", 64'(ready), 64'd1);
    check_value("rst_valid", 64'(valid), 64'd0);
    check_value("rst_root", 64'(root), 64'd0);
    check_value("rst_rem", 64'(rem), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero radicand, latency, ready profile, pulse width
    issue(32'd0, mk(16'd0, 17'd0), 1'b1);
    check_value("busy_ready", 64'(ready), 64'd0);
    wait_valid(k);
    check_value("lat_zero", 64'(k), 64'd17);
    check_value("valid_ready", 64'(ready), 64'd1);
    @(negedge clk);
    check_value("valid_width", 64'(valid), 64'd0);

    // Boundaries
    issue(32'hFFFF_FFFF, mk(16'hFFFF, 17'h1_FFFE), 1'b1);
    wait_valid(k);
    check_value("lat_max", 64'(k), 64'd17);
    issue(32'd99, mk(16'd9, 17'd18), 1'b1);
    wait_valid(k);

    // Back-to-back: second start in the valid cycle
    issue(32'd1_000_000, mk(16'd1000, 17'd0), 1'b1);
    wait_valid(k);
    issue(32'd2, mk(16'd1, 17'd1), 1'b1);
    wait_valid(k);
    check_value("b2b_lat", 64'(k), 64'd17);
    @(negedge clk);

    // Starts while busy are ignored
    issue(32'd12345, mk(16'd111, 17'd24), 1'b1);
    vc = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == 2 || c == 7) begin
        start    = 1'b1;
        radicand = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (valid === 1'b1) vc++;
    end
    start = 1'b0;
    check_value("single_valid", 64'(vc), 64'd1);

    // Reset mid-operation
    issue(32'd3_000_000_000, mk(16'd0, 17'd0), 1'b0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_value("abort_ready", 64'(ready), 64'd1);
    check_value("abort_valid", 64'(valid), 64'd0);
    check_value("abort_root", 64'(root), 64'd0);
    check_value("abort_rem", 64'(rem), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    vc = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (valid === 1'b1) vc++;
    end
    check_value("abort_no_valid", 64'(vc), 64'd0);
    issue(32'd16, mk(16'd4, 17'd0), 1'b1);
    wait_valid(k);
    check_value("lat_after_abort", 64'(k), 64'd17);

    // Corners: 2^k-1, squares and their neighbours
    for (int b = 1; b <= 32; b++) begin
      s64 = (64'd1 << b) - 64'd1;
      x   = s64[31:0];
      issue(x, ref_sqrt(x), 1'b1);
    end
    sq = '{1, 2, 3, 10, 255, 256, 4095, 4096, 46341, 65535};
    for (int i = 0; i < 10; i++) begin
      s64 = 64'(sq[i]) * 64'(sq[i]);
      x   = s64[31:0];
      issue(x, ref_sqrt(x), 1'b1);
      x   = x - 32'd1;
      issue(x, ref_sqrt(x), 1'b1);
      s64 = s64 + 64'd2 * 64'(sq[i]);
      x   = s64[31:0];
      issue(x, ref_sqrt(x), 1'b1);
    end

    // Random operands, a quarter of them small
    for (int i = 0; i < 2000; i++) begin
      if ((i % 4) == 0) x = $urandom_range(0, 65535);
      else              x = $urandom;
      issue(x, ref_sqrt(x), 1'b1);
    end

    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_value("drain", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
